// File: rtl/syspll_rstctl_pkg.sv
// Shared types and helpers for the system PLL reset/lock sequencer.
`timescale 1ns/1ps
package syspll_rstctl_pkg;

  localparam int unsigned RSTCTL_STATE_W = 2;

  typedef enum logic [RSTCTL_STATE_W-1:0] {
    RESET     = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } rstctl_state_t;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/syspll_lock_sync.sv
// Two-flop synchronizer bringing the asynchronous PLL locked flag into refclk.
`timescale 1ns/1ps
module syspll_lock_sync (
  input  logic refclk,
  input  logic rst,
  input  logic pll_locked,
  output logic lock_s
);

  logic meta;

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      meta   <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      meta   <= pll_locked;
      lock_s <= meta;
    end
  end

endmodule

// File: rtl/bemicro_cv_syspll_rstctl.sv
// System PLL reset and lock sequencer: timed PLL reset, lock qualification, system reset release.
// Optional lock-loss counter port enabled by defining SYSPLL_RSTCTL_LOSS_CNT_EN.
`timescale 1ns/1ps
module bemicro_cv_syspll_rstctl
  import syspll_rstctl_pkg::*;
#(
  parameter int unsigned RST_HOLD_CYCLES     = 16,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
  parameter int unsigned CNT_W               = 8
) (
  input  logic                      refclk,
  input  logic                      rst,
  input  logic                      pll_locked,
  input  logic                      sw_relock,
  output logic                      pll_rst,
  output logic                      sys_rst,
  output logic                      ready,
  output logic [RSTCTL_STATE_W-1:0] state
`ifdef SYSPLL_RSTCTL_LOSS_CNT_EN
  ,
  output logic [CNT_W-1:0]          loss_cnt
`endif
);

  localparam int unsigned CNT_MAX = max3(RST_HOLD_CYCLES, LOCK_STABLE_CYCLES, LOCK_TIMEOUT_CYCLES);
  localparam int unsigned W       = $clog2(CNT_MAX + 1);

  logic          lock_s;
  logic [W-1:0]  cnt, cnt_nxt, cnt_load;
  logic          cnt_done;
  rstctl_state_t state_q, state_nxt;

  syspll_lock_sync u_lock_sync (
    .refclk     (refclk),
    .rst        (rst),
    .pll_locked (pll_locked),
    .lock_s     (lock_s)
  );

  // Each timed state is entered with its length loaded and left when cnt reaches 1,
  // so a state with length N occupies exactly N cycles.
  assign cnt_done = (cnt == W'(1));

  always_comb begin
    state_nxt = state_q;
    unique case (state_q)
      RESET: begin
        if (cnt_done) state_nxt = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (sw_relock)     state_nxt = RESET;
        else if (lock_s)   state_nxt = STABLE;
        else if (cnt_done) state_nxt = RESET;
      end
      STABLE: begin
        if (sw_relock)     state_nxt = RESET;
        else if (!lock_s)  state_nxt = WAIT_LOCK;
        else if (cnt_done) state_nxt = RUN;
      end
      RUN: begin
        if (!lock_s || sw_relock) state_nxt = RESET;
      end
      default: state_nxt = RESET;
    endcase
  end

  always_comb begin
    cnt_load = '0;
    unique case (state_nxt)
      RESET:     cnt_load = W'(RST_HOLD_CYCLES);
      WAIT_LOCK: cnt_load = W'(LOCK_TIMEOUT_CYCLES);
      STABLE:    cnt_load = W'(LOCK_STABLE_CYCLES);
      default:   cnt_load = '0;
    endcase
  end

  // Every transition changes state, so a state change is exactly a state entry.
  always_comb begin
    cnt_nxt = cnt;
    if (state_nxt != state_q)  cnt_nxt = cnt_load;
    else if (state_q != RUN)   cnt_nxt = cnt - W'(1);
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q <= RESET;
      cnt     <= W'(RST_HOLD_CYCLES);
      pll_rst <= 1'b1;
      sys_rst <= 1'b1;
      ready   <= 1'b0;
    end else begin
      state_q <= state_nxt;
      cnt     <= cnt_nxt;
      pll_rst <= (state_nxt == RESET);
      sys_rst <= (state_nxt != RUN);
      ready   <= (state_nxt == RUN);
    end
  end

  assign state = state_q;

`ifdef SYSPLL_RSTCTL_LOSS_CNT_EN
  logic loss_ev;

  // Lock loss in RUN counts even if a software re-lock arrives in the same cycle.
  assign loss_ev = (state_q == RUN) && !lock_s;

  always_ff @(posedge refclk or posedge rst) begin
    if (rst)                         loss_cnt <= '0;
    else if (loss_ev && loss_cnt != '1) loss_cnt <= loss_cnt + CNT_W'(1);
  end
`endif

endmodule

// File: tb/tb_bemicro_cv_syspll_rstctl.sv
// Directed self-checking bench for bemicro_cv_syspll_rstctl (HOLD=4, STABLE=8, TIMEOUT=32).
`timescale 1ns/1ps
module tb_bemicro_cv_syspll_rstctl;

  logic       refclk = 1'b0;
  logic       rst = 1'b0;
  logic       pll_locked = 1'b0;
  logic       sw_relock = 1'b0;
  logic       pll_rst, sys_rst, ready;
  logic [1:0] state;
`ifdef SYSPLL_RSTCTL_LOSS_CNT_EN
  logic [7:0] loss_cnt;
`endif

  int checks = 0;
  int failures = 0;

  bemicro_cv_syspll_rstctl #(
    .RST_HOLD_CYCLES     (4),
    .LOCK_STABLE_CYCLES  (8),
    .LOCK_TIMEOUT_CYCLES (32),
    .CNT_W               (8)
  ) dut (
    .refclk     (refclk),
    .rst        (rst),
    .pll_locked (pll_locked),
    .sw_relock  (sw_relock),
    .pll_rst    (pll_rst),
    .sys_rst    (sys_rst),
    .ready      (ready),
    .state      (state)
`ifdef SYSPLL_RSTCTL_LOSS_CNT_EN
    ,
    .loss_cnt   (loss_cnt)
`endif
  );

  always #10 refclk = ~refclk;

  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_loss(input string tag, input int exp);
`ifdef SYSPLL_RSTCTL_LOSS_CNT_EN
    chk(tag, 32'(loss_cnt), 32'(exp));
`else
    if (exp < 0) $display("unused %s", tag);
`endif
  endtask

  // Raise lock and wait (bounded) until the block reaches RUN.
  task automatic relock();
    int n;
    pll_locked = 1'b1;
    n = 0;
    while (!ready && n < 200) begin
      tick();
      n++;
    end
    chk("relock_ready", 32'(ready), 32'd1);
  endtask

  initial begin
    // Power-up reset
    #1 rst = 1'b1;
    repeat (3) tick();
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_pll_rst", 32'(pll_rst), 32'd1);
    chk("rst_sys_rst", 32'(sys_rst), 32'd1);
    chk("rst_ready", 32'(ready), 32'd0);
    chk_loss("rst_loss_cnt", 0);
    rst = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("pwr_hold_pll_rst", 32'(pll_rst), 32'd1);
    end
    tick();
    chk("pwr_hold_end_pll_rst", 32'(pll_rst), 32'd0);
    chk("pwr_wait_state", 32'(state), 32'd1);
    repeat (6) tick();
    pll_locked = 1'b1;
    repeat (10) tick();
    chk("pwr_stable_state", 32'(state), 32'd2);
    chk("pwr_ready_early", 32'(ready), 32'd0);
    tick();
    chk("pwr_ready", 32'(ready), 32'd1);
    chk("pwr_run_state", 32'(state), 32'd3);
    chk("pwr_run_sys_rst", 32'(sys_rst), 32'd0);

    // sw_relock alone in RUN: no loss count
    sw_relock = 1'b1;
    tick();
    sw_relock = 1'b0;
    chk("relock_run_state", 32'(state), 32'd0);
    chk("relock_run_sys_rst", 32'(sys_rst), 32'd1);
    chk_loss("relock_run_loss", 0);
    repeat (3) tick();
    chk("relock_hold_state", 32'(state), 32'd0);
    tick();
    chk("relock_wait_state", 32'(state), 32'd1);
    tick();
    chk("relock_stable_state", 32'(state), 32'd2);

    // One-cycle lock glitch in STABLE after 5 stable cycles
    repeat (4) tick();
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    tick();
    chk("glitch_still_stable", 32'(state), 32'd2);
    tick();
    chk("glitch_wait_state", 32'(state), 32'd1);
    tick();
    chk("glitch_restable", 32'(state), 32'd2);
    repeat (7) tick();
    chk("glitch_ready_early", 32'(ready), 32'd0);
    tick();
    chk("glitch_ready", 32'(ready), 32'd1);

    // Lock loss in RUN, with sw_relock during the following RESET
    pll_locked = 1'b0;
    repeat (2) tick();
    chk("loss_sys_rst_early", 32'(sys_rst), 32'd0);
    tick();
    chk("loss_sys_rst", 32'(sys_rst), 32'd1);
    chk("loss_pll_rst", 32'(pll_rst), 32'd1);
    chk("loss_ready", 32'(ready), 32'd0);
    chk_loss("loss_cnt_1", 1);
    pll_locked = 1'b1;
    tick();
    sw_relock = 1'b1;
    tick();
    sw_relock = 1'b0;
    tick();
    chk("reset_relock_hold", 32'(pll_rst), 32'd1);
    tick();
    chk("reset_relock_not_ext", 32'(pll_rst), 32'd0);
    repeat (9) tick();
    chk("loss_recover_ready", 32'(ready), 32'd1);

    // Simultaneous lock loss and sw_relock in RUN
    pll_locked = 1'b0;
    repeat (2) tick();
    sw_relock = 1'b1;
    tick();
    sw_relock = 1'b0;
    chk("simul_state", 32'(state), 32'd0);
    chk_loss("simul_loss_cnt", 2);

    // Timeout with lock held low: 4 cycles reset every 36
    for (int k = 1; k <= 72; k++) begin
      tick();
      chk($sformatf("timeout_pll_rst_k%0d", k), 32'(pll_rst), 32'((k % 36) < 4));
    end
    chk_loss("timeout_loss_cnt", 2);

    // sw_relock in WAIT_LOCK
    repeat (4) tick();
    chk("wait_state", 32'(state), 32'd1);
    sw_relock = 1'b1;
    tick();
    sw_relock = 1'b0;
    chk("wait_relock_state", 32'(state), 32'd0);
    chk("wait_relock_pll_rst", 32'(pll_rst), 32'd1);

    // Repeated lock loss: counter saturates
    for (int i = 0; i < 300; i++) begin
      relock();
      pll_locked = 1'b0;
      repeat (3) tick();
      chk("sat_loop_sys_rst", 32'(sys_rst), 32'd1);
    end
    chk_loss("sat_loss_cnt", 255);

    // Mid-run asynchronous reset
    relock();
    #4 rst = 1'b1;
    #2;
    chk("async_state", 32'(state), 32'd0);
    chk("async_pll_rst", 32'(pll_rst), 32'd1);
    chk("async_sys_rst", 32'(sys_rst), 32'd1);
    chk("async_ready", 32'(ready), 32'd0);
    chk_loss("async_loss_cnt", 0);
    tick();
    rst = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("rerst_hold_pll_rst", 32'(pll_rst), 32'd1);
    end
    tick();
    chk("rerst_hold_end", 32'(pll_rst), 32'd0);
    repeat (10) tick();
    chk("rerst_ready", 32'(ready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
